// File: rtl/game_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : game_status_tx
// Purpose  : Formats game start/score/over events as ASCII lines and drives
//            the byte-level transmit handshake of the shared UART.
// Options  : GAME_STATUS_TX_HEARTBEAT_EN adds a periodic "." heartbeat byte.
// Revision : 1.0 - initial release
// ============================================================================
module game_status_tx #(
    parameter int HB_TICK = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        over,
    input  logic [15:0] score,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_GO = 2'd0,
        M_SC = 2'd1,
        M_OV = 2'd2,
        M_HB = 2'd3
    } msg_t;

    state_t      r_state, w_state_nxt;
    msg_t        r_msg, w_msg_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [15:0] r_snap;
    logic        r_prev_start, r_prev_over;
    logic [15:0] r_prev_score;
    logic        r_pend_go, r_pend_sc, r_pend_ov;
    logic        r_transmit;
    logic [7:0]  r_tx_byte;

    logic        w_ev_go, w_ev_sc, w_ev_ov;
    logic        w_any_pend;
    logic        w_sel, w_fire;
    logic        w_clr_go, w_clr_sc, w_clr_ov;
    logic        w_hb_due;
    logic [7:0]  w_byte;
    logic [3:0]  w_last_idx;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    assign w_ev_go    = start & ~r_prev_start;
    assign w_ev_ov    = over & ~r_prev_over;
    assign w_ev_sc    = start & (score != r_prev_score);
    assign w_any_pend = r_pend_go | r_pend_sc | r_pend_ov;

`ifdef GAME_STATUS_TX_HEARTBEAT_EN
    logic [31:0] r_hb_cnt;

    assign w_hb_due = (r_hb_cnt == 32'(HB_TICK - 1));

    // Counts only idle time with nothing queued; any selection restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hb_cnt <= 32'd0;
        end else if (w_sel) begin
            r_hb_cnt <= 32'd0;
        end else if ((r_state == S_IDLE) && !w_any_pend) begin
            r_hb_cnt <= r_hb_cnt + 32'd1;
        end
    end
`else
    logic w_unused_hb;

    assign w_hb_due    = 1'b0;
    assign w_unused_hb = (HB_TICK != 0);
`endif

    // Byte table: digits come from the snapshot taken at selection.
    always_comb begin
        w_byte     = 8'h00;
        w_last_idx = 4'd8;
        case (r_msg)
            M_GO: begin
                w_last_idx = 4'd3;
                case (r_idx)
                    4'd0:    w_byte = 8'h47;
                    4'd1:    w_byte = 8'h4F;
                    4'd2:    w_byte = 8'h0D;
                    default: w_byte = 8'h0A;
                endcase
            end
            M_HB: begin
                w_last_idx = 4'd0;
                w_byte     = 8'h2E;
            end
            default: begin
                case (r_idx)
                    4'd0:    w_byte = (r_msg == M_SC) ? 8'h53 : 8'h4F;
                    4'd1:    w_byte = (r_msg == M_SC) ? 8'h43 : 8'h56;
                    4'd2:    w_byte = 8'h20;
                    4'd3:    w_byte = digit_ascii(r_snap[15:12]);
                    4'd4:    w_byte = digit_ascii(r_snap[11:8]);
                    4'd5:    w_byte = digit_ascii(r_snap[7:4]);
                    4'd6:    w_byte = digit_ascii(r_snap[3:0]);
                    4'd7:    w_byte = 8'h0D;
                    default: w_byte = 8'h0A;
                endcase
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_msg_nxt   = r_msg;
        w_idx_nxt   = r_idx;
        w_sel       = 1'b0;
        w_fire      = 1'b0;
        w_clr_go    = 1'b0;
        w_clr_sc    = 1'b0;
        w_clr_ov    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_go) begin
                    w_sel     = 1'b1;
                    w_msg_nxt = M_GO;
                    w_clr_go  = 1'b1;
                end else if (r_pend_sc) begin
                    w_sel     = 1'b1;
                    w_msg_nxt = M_SC;
                    w_clr_sc  = 1'b1;
                end else if (r_pend_ov) begin
                    w_sel     = 1'b1;
                    w_msg_nxt = M_OV;
                    w_clr_ov  = 1'b1;
                end else if (w_hb_due) begin
                    w_sel     = 1'b1;
                    w_msg_nxt = M_HB;
                end
                if (w_sel) begin
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!is_transmitting) begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (is_transmitting) begin
                    w_state_nxt = S_WAIT_LO;
                end
            end
            default: begin
                if (!is_transmitting) begin
                    if (r_idx == w_last_idx) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
        endcase
    end

    // A new event in the selection cycle re-arms its flag rather than being lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_msg        <= M_GO;
            r_idx        <= 4'd0;
            r_snap       <= 16'h0000;
            r_prev_start <= 1'b0;
            r_prev_over  <= 1'b0;
            r_prev_score <= 16'h0000;
            r_pend_go    <= 1'b0;
            r_pend_sc    <= 1'b0;
            r_pend_ov    <= 1'b0;
            r_transmit   <= 1'b0;
            r_tx_byte    <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_msg        <= w_msg_nxt;
            r_idx        <= w_idx_nxt;
            r_prev_start <= start;
            r_prev_over  <= over;
            r_prev_score <= score;
            r_pend_go    <= (r_pend_go & ~w_clr_go) | w_ev_go;
            r_pend_sc    <= (r_pend_sc & ~w_clr_sc) | w_ev_sc;
            r_pend_ov    <= (r_pend_ov & ~w_clr_ov) | w_ev_ov;
            if (w_sel) begin
                r_snap <= score;
            end
            r_transmit <= w_fire;
            if (w_fire) begin
                r_tx_byte <= w_byte;
            end
        end
    end

    assign transmit = r_transmit;
    assign tx_byte  = r_tx_byte;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_game_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_status_tx
// Purpose  : Self-checking bench for game_status_tx with a stretching UART model
//            and a line-formatting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_status_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        over;
    logic [15:0] score;
    logic        is_transmitting;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hb_count = 0;
    int          uart_cnt = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];

    game_status_tx #(.HB_TICK(100)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .over            (over),
        .score           (score),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in: each accepted byte keeps the line busy 10 cycles.
    initial is_transmitting = 1'b0;
    always @(posedge clk) begin
        if (uart_cnt != 0) begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) is_transmitting <= 1'b0;
        end else if (transmit) begin
            is_transmitting <= 1'b1;
            uart_cnt        <= 10;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (transmit === 1'b1) begin
            check("strobe_while_tx", {15'd0, is_transmitting}, 16'd0);
            if (tx_byte == 8'h2E) hb_count++;
            else rx_q.push_back(tx_byte);
        end
    end

    function automatic logic [7:0] ascii_digit(input int d);
        return (d < 10) ? 8'(8'h30 + d) : 8'h3F;
    endfunction

    task automatic expect_line(input string kind, input logic [15:0] val);
        if (kind == "GO") begin
            exp_q.push_back("G"); exp_q.push_back("O");
        end else begin
            exp_q.push_back(kind[0]); exp_q.push_back(kind[1]); exp_q.push_back(" ");
            for (int k = 3; k >= 0; k--) exp_q.push_back(ascii_digit(int'((val >> (4 * k)) & 16'hF)));
        end
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        logic timed_out = 1'b0;
        while (quiet < 6) begin
            @(negedge clk);
            n++;
            if (!busy && !is_transmitting) quiet++;
            else quiet = 0;
            if (n > 3000) begin
                timed_out = 1'b1;
                quiet = 6;
            end
        end
        check({tag, "_timeout"}, {15'd0, timed_out}, 16'd0);
    endtask

    task automatic wait_rx(input int count);
        int n = 0;
        logic timed_out = 1'b0;
        while (rx_q.size() < count && !timed_out) begin
            @(negedge clk);
            n++;
            if (n > 1000) timed_out = 1'b1;
        end
        check("wait_rx_timeout", {15'd0, timed_out}, 16'd0);
    endtask

    task automatic compare_lines(input string tag);
        wait_idle(tag);
        check({tag, "_len"}, 16'(rx_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {8'h00, rx_q[i]}, {8'h00, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] v1, v2, v3;
        int hb_base;
        rst = 1'b1; start = 1'b0; over = 1'b0; score = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_transmit", {15'd0, transmit}, 16'd0);
        check("reset_tx_byte", {8'h00, tx_byte}, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Start of game.
        start = 1'b1;
        expect_line("GO", 16'h0000);
        compare_lines("go");
        check("go_busy_after", {15'd0, busy}, 16'd0);

        // Score step while running.
        score = 16'h0123;
        expect_line("SC", 16'h0123);
        compare_lines("sc0123");

        // Random score changes, each sent on its own.
        repeat (3) begin
            v1 = rand_bcd();
            if (v1 == score) v1 = v1 ^ 16'h0001;
            score = v1;
            expect_line("SC", v1);
            compare_lines("sc_rand");
        end

        // Two changes during a message coalesce into one line with the later value.
        v1 = rand_bcd();
        if (v1 == score) v1 = v1 ^ 16'h0100;
        v2 = v1 ^ 16'h0001;
        v3 = v1 ^ 16'h0010;
        score = v1;
        expect_line("SC", v1);
        wait_rx(3);
        @(negedge clk) score = v2;
        @(negedge clk) score = v3;
        expect_line("SC", v3);
        compare_lines("sc_coalesce");

        // Game over with a non-decimal digit.
        start = 1'b0;
        @(negedge clk);
        score = 16'h0A07; over = 1'b1;
        expect_line("OV", 16'h0A07);
        compare_lines("ov_0a07");
        over = 1'b0;
        repeat (2) begin
            @(negedge clk);
            v1 = 16'($urandom);
            score = v1; over = 1'b1;
            expect_line("OV", v1);
            compare_lines("ov_rand");
            over = 1'b0;
        end

        // Start and score change together: GO first, then SC.
        @(negedge clk);
        v1 = rand_bcd();
        if (v1 == score) v1 = v1 ^ 16'h1000;
        start = 1'b1; score = v1;
        expect_line("GO", 16'h0000);
        expect_line("SC", v1);
        compare_lines("go_sc");

        // Reset after the third byte abandons the line.
        v1 = rand_bcd();
        if (v1 == score) v1 = v1 ^ 16'h0001;
        score = v1;
        wait_rx(3);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; score = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_transmit", {15'd0, transmit}, 16'd0);
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_tx_byte", {8'h00, tx_byte}, 16'h0000);
        exp_q.push_back("S"); exp_q.push_back("C"); exp_q.push_back(" ");
        repeat (40) @(negedge clk);
        compare_lines("midrst");

        // Idle period: heartbeat only when the option is built in.
        hb_base = hb_count;
        repeat (400) @(negedge clk);
`ifdef GAME_STATUS_TX_HEARTBEAT_EN
        check("heartbeat_seen", {15'd0, (hb_count - hb_base) >= 2}, 16'd1);
`else
        check("heartbeat_none", 16'(hb_count - hb_base), 16'd0);
`endif
        check("idle_no_event_bytes", 16'(rx_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
